// File: rtl/pc_sequencer_if.sv
// Bundle of fetch-port and decode-stage signals seen by the next-PC controller.
// The master side is the sequencer itself; the slave side is the surrounding pipeline.
interface pc_sequencer_if;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] pc;
  logic        id_valid;
  logic [2:0]  id_op;
  logic [31:0] id_pc;
  logic [25:0] id_instr_index;
  logic [15:0] id_br_offset;
  logic        id_br_taken;
  logic [31:0] id_rs_data;
  logic        flush;
  logic [31:0] link_addr;
  logic        redirect;
  logic        addr_err;
  logic [31:0] bad_vaddr;

  modport master (
    input  if_ready, id_valid, id_op, id_pc, id_instr_index, id_br_offset,
           id_br_taken, id_rs_data, flush,
    output if_valid, pc, link_addr, redirect, addr_err, bad_vaddr
  );

  modport slave (
    output if_ready, id_valid, id_op, id_pc, id_instr_index, id_br_offset,
           id_br_taken, id_rs_data, flush,
    input  if_valid, pc, link_addr, redirect, addr_err, bad_vaddr
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC controller: owns the fetch PC, forms J/branch/JR targets,
// holds a taken target until its delay slot is accepted, and redirects on flush/address error.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] EXC_PC   = 32'hBFC0_0380
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  typedef enum logic {RUN, PEND} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pendPc_q, pendPc_d;
  logic        ifValid_q;
  logic        redirect_q, redirect_d;
  logic        addrErr_q, addrErr_d;
  logic [31:0] badVaddr_q, badVaddr_d;

  logic [31:0] pc4;
  logic [31:0] target;
  logic        req;
  logic        jrMisaligned;
  logic        accept;

  // Decode-side target formation; the target mux is only meaningful when req is set.
  always_comb begin
    pc4          = bus.id_pc + 32'd4;
    req          = 1'b0;
    jrMisaligned = 1'b0;
    target       = pc4;
    if (bus.id_valid) begin
      case (bus.id_op)
        3'd1, 3'd2: begin
          req    = 1'b1;
          target = {pc4[31:28], bus.id_instr_index, 2'b00};
        end
        3'd3: begin
          req          = 1'b1;
          target       = bus.id_rs_data;
          jrMisaligned = (bus.id_rs_data[1:0] != 2'b00);
        end
        3'd4: begin
          req    = bus.id_br_taken;
          target = pc4 + {{14{bus.id_br_offset[15]}}, bus.id_br_offset, 2'b00};
        end
        default: ;
      endcase
    end
  end

  assign accept = ifValid_q && bus.if_ready;

  // Next-state logic: flush outranks everything, and requests seen while a target is pending are dropped.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pendPc_d   = pendPc_q;
    redirect_d = 1'b0;
    addrErr_d  = 1'b0;
    badVaddr_d = badVaddr_q;
    if (bus.flush) begin
      state_d    = RUN;
      pc_d       = EXC_PC;
      pendPc_d   = 32'd0;
      redirect_d = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (jrMisaligned) begin
            pc_d       = EXC_PC;
            redirect_d = 1'b1;
            addrErr_d  = 1'b1;
            badVaddr_d = bus.id_rs_data;
          end else if (req) begin
            if (accept) begin
              pc_d       = target;
              redirect_d = 1'b1;
            end else begin
              pendPc_d = target;
              state_d  = PEND;
            end
          end else if (accept) begin
            pc_d = pc_q + 32'd4;
          end
        end
        PEND: begin
          if (accept) begin
            pc_d       = pendPc_q;
            state_d    = RUN;
            redirect_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pendPc_q   <= 32'd0;
      ifValid_q  <= 1'b0;
      redirect_q <= 1'b0;
      addrErr_q  <= 1'b0;
      badVaddr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pendPc_q   <= pendPc_d;
      ifValid_q  <= 1'b1;
      redirect_q <= redirect_d;
      addrErr_q  <= addrErr_d;
      badVaddr_q <= badVaddr_d;
    end
  end

  assign bus.if_valid  = ifValid_q;
  assign bus.pc        = pc_q;
  assign bus.redirect  = redirect_q;
  assign bus.addr_err  = addrErr_q;
  assign bus.bad_vaddr = badVaddr_q;
  assign bus.link_addr = bus.id_pc + 32'd8;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios against hand-derived constants,
// then random traffic against a cycle-level behavioural model of the next-PC rules.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC   = 32'hBFC0_0380;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: a pending target is represented by a non-empty queue.
  logic [31:0] mPc;
  logic        mValid;
  logic        mRed;
  logic        mErr;
  logic [31:0] mBad;
  logic [31:0] pendQ[$];

  function automatic logic [31:0] branchTarget(logic [31:0] idPc, logic [15:0] off);
    int signed delta;
    delta = int'($signed(off)) * 4;
    return idPc + 32'd4 + 32'(delta);
  endfunction

  task automatic modelStep();
    logic        acc;
    logic        req;
    logic        mis;
    logic [31:0] tgt;
    if (!rst) begin
      mPc = RESET_PC; mValid = 1'b0; mRed = 1'b0; mErr = 1'b0; mBad = 32'd0;
      pendQ.delete();
    end else begin
      acc = mValid && bus.if_ready;
      req = 1'b0; mis = 1'b0; tgt = 32'd0;
      if (bus.id_valid) begin
        if (bus.id_op == 3'd1 || bus.id_op == 3'd2) begin
          req = 1'b1;
          tgt = ((bus.id_pc + 32'd4) & 32'hF000_0000) | ({6'd0, bus.id_instr_index} << 2);
        end else if (bus.id_op == 3'd3) begin
          req = 1'b1;
          tgt = bus.id_rs_data;
          mis = (bus.id_rs_data % 4) != 0;
        end else if (bus.id_op == 3'd4 && bus.id_br_taken) begin
          req = 1'b1;
          tgt = branchTarget(bus.id_pc, bus.id_br_offset);
        end
      end
      mRed = 1'b0; mErr = 1'b0;
      if (bus.flush) begin
        mPc = EXC_PC; mRed = 1'b1; pendQ.delete();
      end else if (pendQ.size() > 0) begin
        if (acc) begin mPc = pendQ.pop_front(); mRed = 1'b1; end
      end else if (mis) begin
        mPc = EXC_PC; mRed = 1'b1; mErr = 1'b1; mBad = bus.id_rs_data;
      end else if (req) begin
        if (acc) begin mPc = tgt; mRed = 1'b1; end
        else pendQ.push_back(tgt);
      end else if (acc) begin
        mPc = mPc + 32'd4;
      end
      mValid = 1'b1;
    end
  endtask

  // Advance one clock with the inputs currently on the bus; outputs sampled 1 time unit after the edge.
  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_op = 3'd0; bus.id_br_taken = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.if_ready = 1'b1; idle();
    bus.id_pc = 32'd0; bus.id_instr_index = 26'd0; bus.id_br_offset = 16'd0; bus.id_rs_data = 32'd0;
    cycle(); cycle();
    checks++; if (bus.pc !== RESET_PC) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc, RESET_PC); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.if_valid); end
    checks++; if (bus.redirect !== 1'b0 || bus.addr_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b%b expected 00", bus.redirect, bus.addr_err); end
    checks++; if (bus.bad_vaddr !== 32'd0) begin errors++; $display("[TB] FAIL reset_badvaddr: got %h expected 0", bus.bad_vaddr); end
    rst = 1'b1;
    cycle();
    checks++; if (bus.if_valid !== 1'b1 || bus.pc !== RESET_PC) begin errors++; $display("[TB] FAIL release: got valid=%b pc=%h expected valid=1 pc=%h", bus.if_valid, bus.pc, RESET_PC); end
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checks++; if (bus.pc !== RESET_PC + 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_pc%0d: got %h expected %h", i, bus.pc, RESET_PC + 32'(4 * i)); end
    end
  endtask

  task automatic test_jump();
    bus.id_valid = 1'b1; bus.id_op = 3'd1; bus.id_pc = 32'h8000_1000; bus.id_instr_index = 26'h0000040;
    bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.link_addr !== 32'h8000_1008) begin errors++; $display("[TB] FAIL j_link: got %h expected 80001008", bus.link_addr); end
    cycle();
    checks++; if (bus.pc !== 32'h8000_0100) begin errors++; $display("[TB] FAIL j_pc: got %h expected 80000100", bus.pc); end
    checks++; if (bus.redirect !== 1'b1) begin errors++; $display("[TB] FAIL j_redirect: got %b expected 1", bus.redirect); end
    idle();
    cycle();
    checks++; if (bus.redirect !== 1'b0 || bus.pc !== 32'h8000_0104) begin errors++; $display("[TB] FAIL j_after: got red=%b pc=%h expected red=0 pc=80000104", bus.redirect, bus.pc); end
  endtask

  task automatic test_branch_stall();
    bus.id_valid = 1'b1; bus.id_op = 3'd3; bus.id_rs_data = 32'h0000_0014; bus.if_ready = 1'b1;
    cycle();
    checks++; if (bus.pc !== 32'h14) begin errors++; $display("[TB] FAIL jr_to_14: got %h expected 00000014", bus.pc); end
    bus.id_op = 3'd4; bus.id_br_taken = 1'b1; bus.id_pc = 32'h10; bus.id_br_offset = 16'hFFFF; bus.if_ready = 1'b0;
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.pc !== 32'h14 || bus.redirect !== 1'b0) begin errors++; $display("[TB] FAIL br_stall%0d: got pc=%h red=%b expected pc=00000014 red=0", i, bus.pc, bus.redirect); end
      if (i < 2) cycle();
    end
    bus.if_ready = 1'b1;
    cycle();
    checks++; if (bus.pc !== 32'h10 || bus.redirect !== 1'b1) begin errors++; $display("[TB] FAIL br_issue: got pc=%h red=%b expected pc=00000010 red=1", bus.pc, bus.redirect); end
  endtask

  task automatic test_branch_wrap();
    bus.id_valid = 1'b1; bus.id_op = 3'd4; bus.id_br_taken = 1'b1;
    bus.id_pc = 32'hFFFF_FFF8; bus.id_br_offset = 16'h0002; bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.link_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_link: got %h expected 00000000", bus.link_addr); end
    cycle();
    checks++; if (bus.pc !== 32'h4) begin errors++; $display("[TB] FAIL wrap_pc: got %h expected 00000004", bus.pc); end
    idle();
  endtask

  task automatic test_jr();
    bus.id_valid = 1'b1; bus.id_op = 3'd3; bus.id_rs_data = 32'h0040_0002; bus.if_ready = 1'b0;
    cycle();
    checks++; if (bus.pc !== EXC_PC) begin errors++; $display("[TB] FAIL jr_bad_pc: got %h expected %h", bus.pc, EXC_PC); end
    checks++; if (bus.addr_err !== 1'b1 || bus.bad_vaddr !== 32'h0040_0002) begin errors++; $display("[TB] FAIL jr_bad_err: got err=%b bad=%h expected err=1 bad=00400002", bus.addr_err, bus.bad_vaddr); end
    idle(); bus.if_ready = 1'b1;
    cycle();
    checks++; if (bus.addr_err !== 1'b0 || bus.bad_vaddr !== 32'h0040_0002) begin errors++; $display("[TB] FAIL jr_err_pulse: got err=%b bad=%h expected err=0 bad=00400002", bus.addr_err, bus.bad_vaddr); end
    bus.id_valid = 1'b1; bus.id_op = 3'd3; bus.id_rs_data = 32'h0040_0000;
    cycle();
    checks++; if (bus.pc !== 32'h0040_0000 || bus.addr_err !== 1'b0) begin errors++; $display("[TB] FAIL jr_ok: got pc=%h err=%b expected pc=00400000 err=0", bus.pc, bus.addr_err); end
    idle();
  endtask

  task automatic test_flush_pend();
    bus.id_valid = 1'b1; bus.id_op = 3'd1; bus.id_pc = 32'h0000_2000; bus.id_instr_index = 26'h0001000;
    bus.if_ready = 1'b0;
    cycle();
    idle(); bus.flush = 1'b1; bus.if_ready = 1'b1;
    cycle();
    checks++; if (bus.pc !== EXC_PC || bus.redirect !== 1'b1) begin errors++; $display("[TB] FAIL flush_pend: got pc=%h red=%b expected pc=%h red=1", bus.pc, bus.redirect, EXC_PC); end
    bus.flush = 1'b0;
    cycle();
    checks++; if (bus.pc !== EXC_PC + 32'd4) begin errors++; $display("[TB] FAIL flush_drop: got %h expected %h", bus.pc, EXC_PC + 32'd4); end
  endtask

  task automatic test_reset_pend();
    bus.id_valid = 1'b1; bus.id_op = 3'd2; bus.id_pc = 32'h0000_3000; bus.id_instr_index = 26'h0002000;
    bus.if_ready = 1'b0;
    cycle();
    idle(); rst = 1'b0; bus.if_ready = 1'b1;
    cycle();
    checks++; if (bus.pc !== RESET_PC || bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_pend: got pc=%h valid=%b expected pc=%h valid=0", bus.pc, bus.if_valid, RESET_PC); end
    rst = 1'b1;
    cycle(); cycle();
    checks++; if (bus.pc !== RESET_PC + 32'd4 || bus.redirect !== 1'b0) begin errors++; $display("[TB] FAIL rst_drop: got pc=%h red=%b expected pc=%h red=0", bus.pc, bus.redirect, RESET_PC + 32'd4); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      rst                = ($urandom_range(0, 49) != 0);
      bus.if_ready       = ($urandom_range(0, 9) < 6);
      bus.id_valid       = ($urandom_range(0, 3) != 0);
      bus.id_op          = 3'($urandom_range(0, 7));
      bus.id_pc          = {$urandom} & 32'hFFFF_FFFC;
      bus.id_instr_index = 26'($urandom);
      bus.id_br_offset   = 16'($urandom);
      bus.id_br_taken    = 1'($urandom);
      bus.id_rs_data     = ($urandom_range(0, 3) == 0) ? $urandom : ({$urandom} & 32'hFFFF_FFFC);
      bus.flush          = ($urandom_range(0, 15) == 0);
      #1;
      checks++; if (bus.link_addr !== bus.id_pc + 32'd8) begin errors++; $display("[TB] FAIL rnd_link@%0d: got %h expected %h", n, bus.link_addr, bus.id_pc + 32'd8); end
      cycle();
      checks++; if (bus.pc !== mPc) begin errors++; $display("[TB] FAIL rnd_pc@%0d: got %h expected %h", n, bus.pc, mPc); end
      checks++; if (bus.if_valid !== mValid) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", n, bus.if_valid, mValid); end
      checks++; if (bus.redirect !== mRed) begin errors++; $display("[TB] FAIL rnd_redirect@%0d: got %b expected %b", n, bus.redirect, mRed); end
      checks++; if (bus.addr_err !== mErr) begin errors++; $display("[TB] FAIL rnd_addr_err@%0d: got %b expected %b", n, bus.addr_err, mErr); end
      checks++; if (bus.bad_vaddr !== mBad) begin errors++; $display("[TB] FAIL rnd_bad_vaddr@%0d: got %h expected %h", n, bus.bad_vaddr, mBad); end
    end
  endtask

  // Hard stop in case the clock or a scenario ever wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors = 0; checks = 0;
    mPc = 32'd0; mValid = 1'b0; mRed = 1'b0; mErr = 1'b0; mBad = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_jump();
    test_branch_stall();
    test_branch_wrap();
    test_jr();
    test_flush_pend();
    test_reset_pend();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the fetch stage of the MIPS32 core. It owns the fetch PC register and forms jump targets ({PC+4[31:28], instr_index, 2'b00}), branch targets and register-jump targets. It also enforces the one-instruction delay slot when fetch is back-pressured, and redirects to the exception vector on flush or misaligned JR. It sits between the decode stage, which resolves control flow, and the instruction-fetch port.

## Interface

- RESET_PC, 32'hBFC0_0000, fetch address after reset
- EXC_PC, 32'hBFC0_0380, fetch address after flush or address error

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low: state cleared on rising clk edge while rst==0
- if_ready  in  1  fetch port accepts pc this cycle
- if_valid  out  1  pc is a valid fetch request
- pc  out  32  current fetch address
- id_valid  in  1  decode stage holds a valid instruction
- id_op  in  3  0 none, 1 J, 2 JAL, 3 JR/JALR, 4 conditional branch; 5-7 treated as none
- id_pc  in  32  address of the decoding instruction
- id_instr_index  in  26  J/JAL index field
- id_br_offset  in  16  branch offset field
- id_br_taken  in  1  branch condition result (op 4 only)
- id_rs_data  in  32  JR/JALR target
- flush  in  1  exception/eret redirect to EXC_PC
- link_addr  out  32  id_pc + 8, combinational
- redirect  out  1  registered pulse: pc was loaded with a non-sequential target
- addr_err  out  1  registered pulse: JR target misaligned
- bad_vaddr  out  32  offending JR target, held until next addr_err

## Operation

- Accept: a fetch is accepted in a cycle when if_valid and if_ready are both 1.
- Redirect request (req): id_valid=1 and either op is 1/2/3, or op is 4 with id_br_taken=1.
- Targets (pc4 = id_pc+4, mod 2^32):
  - J/JAL: {pc4[31:28], id_instr_index, 2'b00}.
  - Branch: pc4 + (sign-extended id_br_offset << 2), wraps mod 2^32.
  - JR: id_rs_data. If id_rs_data[1:0] != 0, the target is EXC_PC, addr_err pulses, and bad_vaddr <= id_rs_data.
- States:
  - RUN: normal sequential fetch.
  - PEND: target latched, delay slot not yet accepted.
  - After reset, state is RUN.
- RUN behaviour:
  - req and accept: pc <= target. The current pc is the delay slot (id_pc+4) and is fetched first.
  - req and no accept: latch target into pend_pc, go to PEND, pc held.
  - no req and accept: pc <= pc+4.
  - Otherwise pc held.
- PEND behaviour:
  - accept: pc <= pend_pc, go to RUN, redirect=1.
  - no accept: hold.
  - Any req in PEND is ignored; the delay slot cannot hold a branch.
- flush has highest priority in any state: pc <= EXC_PC, go to RUN, pend_pc discarded, concurrent req ignored, redirect=1.
- Misaligned JR in RUN behaves like a flush to EXC_PC. There is no delay-slot wait, and no PEND entry.

## Timing

- Reset values (rst==0 at edge): pc=RESET_PC, if_valid=0, redirect=0, addr_err=0, bad_vaddr=0, state RUN, pend_pc=0. The first cycle after reset release has if_valid=1.
- Reset asserted mid-PEND drops the pending target.
- if_valid is 1 in every non-reset cycle.
- pc changes only on accept, flush, or addr_err, and never during if_ready=0 otherwise.
- Redirect latency: target appears on pc the cycle after the delay-slot accept. That is one cycle if the accept coincides with req; otherwise N+1 cycles for N stall cycles.
- redirect and addr_err are high for exactly one cycle, the cycle in which the new pc is first visible.
- link_addr is purely combinational from id_pc, zero latency.
- Simultaneous flush and PEND accept: flush wins, pc=EXC_PC.

## Test plan

- Reset then release with if_ready=1 for 3 cycles -> pc = BFC00000, BFC00004, BFC00008, BFC0000C; if_valid 0 in reset, then 1.
- J with id_pc=0x8000_1000, index=0x0000040, if_ready=1 -> next pc=0x8000_0100, redirect pulse; link_addr=0x8000_1008.
- Taken branch with id_pc=0x0000_0010, offset=0xFFFF, if_ready=0 for 3 cycles then 1 -> pc holds 0x14 (delay slot) through the stall, then 0x10 one cycle after the accept.
- Branch target wrap: id_pc=0xFFFF_FFF8, offset=0x0002 -> target 0x0000_0004.
- JR with id_rs_data=0x0040_0002 -> pc=EXC_PC, addr_err pulse, bad_vaddr=0x0040_0002; JR with 0x0040_0000 -> pc=0x0040_0000, addr_err 0.
- flush asserted while in PEND with if_ready=1 -> pc=EXC_PC, pending target never issued. Also rst=0 asserted mid-PEND -> pc=RESET_PC.
